// File: rtl/slice_column_renderer_if.sv
// Column draw request/handshake plus the VGA adapter pixel-write bus.
// Latency: none, wiring only.
// Backpressure: start is only honoured while ready=1; the pixel bus has no stall.
interface slice_column_renderer_if;
    // Request side: column sequencer to renderer
    logic       start;
    logic [7:0] column;
    logic [6:0] slice_size;
    logic       ready;
    logic       done;

    // Pixel side: renderer to VGA adapter
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    // Renderer view
    modport slave (
        input  start,
        input  column,
        input  slice_size,
        output ready,
        output done,
        output x,
        output y,
        output colour,
        output plot
    );

    // Sequencer / adapter view
    modport master (
        output start,
        output column,
        output slice_size,
        input  ready,
        input  done,
        input  x,
        input  y,
        input  colour,
        input  plot
    );
endinterface

// File: rtl/slice_column_renderer.sv
// Rasterises one screen column (ceiling / centred wall band / floor), one pixel per clock.
// Latency: first pixel one clock after the accepting edge, done 121 clocks after it, idle at 122.
// Backpressure: none on the pixel bus; start is ignored while busy (ready=0), nothing is queued.
module slice_column_renderer #(
    parameter int             SCREEN_W     = 160,
    parameter int             SCREEN_H     = 120,
    parameter logic [2:0]     CEIL_COLOUR  = 3'b001,
    parameter logic [2:0]     WALL_COLOUR  = 3'b111,
    parameter logic [2:0]     FLOOR_COLOUR = 3'b010
) (
    input  logic                    clock,
    input  logic                    resetn,
    slice_column_renderer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] SCREEN_W_8 = 8'(SCREEN_W);
    localparam logic [7:0] SCREEN_H_8 = 8'(SCREEN_H);

    logic [1:0] state_q,  state_d;
    logic [7:0] col_q,    col_d;
    logic [6:0] size_q,   size_d;
    logic [7:0] top_q,    top_d;
    logic [7:0] bottom_q, bottom_d;
    // Index of the next row to emit: row 0 leaves during setup, so DRAW starts at 1
    logic [6:0] row_q,    row_d;

    logic [7:0] x_q,      x_d;
    logic [6:0] y_q,      y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q,   plot_d;
    logic       done_q,   done_d;

    logic [7:0] h_clamped;
    logic [7:0] top_c;
    logic [7:0] bottom_c;

    // Pixel colour for a row against the wall band [top, bottom)
    function automatic logic [2:0] band_colour(input logic [7:0] row,
                                               input logic [7:0] top,
                                               input logic [7:0] bottom);
        if (row < top) begin
            band_colour = CEIL_COLOUR;
        end else if (row < bottom) begin
            band_colour = WALL_COLOUR;
        end else begin
            band_colour = FLOOR_COLOUR;
        end
    endfunction

    // Wall band from the latched height: clamp to screen height, centre vertically
    always_comb begin
        h_clamped = {1'b0, size_q};
        if ({1'b0, size_q} > SCREEN_H_8) begin
            h_clamped = SCREEN_H_8;
        end
        top_c    = (SCREEN_H_8 - h_clamped) >> 1;
        bottom_c = top_c + h_clamped;
    end

    // Next-state, input latching and registered pixel outputs
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        size_d   = size_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    col_d   = bus.column;
                    size_d  = bus.slice_size;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                // Band is registered for DRAW, but row 0 must leave on this
                // same edge, so it is coloured from the combinational band.
                top_d    = top_c;
                bottom_d = bottom_c;
                x_d      = col_q;
                y_d      = 7'd0;
                colour_d = band_colour(8'd0, top_c, bottom_c);
                plot_d   = (col_q < SCREEN_W_8);
                row_d    = 7'd1;
                state_d  = S_DRAW;
            end

            S_DRAW: begin
                if ({1'b0, row_q} == SCREEN_H_8) begin
                    // Last row already left on the previous edge
                    done_d  = 1'b1;
                    row_d   = 7'd0;
                    state_d = S_DONE;
                end else begin
                    x_d      = col_q;
                    y_d      = row_q;
                    colour_d = band_colour({1'b0, row_q}, top_q, bottom_q);
                    plot_d   = (col_q < SCREEN_W_8);
                    row_d    = row_q + 7'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any draw immediately
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            col_q    <= 8'd0;
            size_q   <= 7'd0;
            top_q    <= 8'd0;
            bottom_q <= 8'd0;
            row_q    <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            size_q   <= size_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule
